// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath enables, ALU operation and operand selects.
module mc_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pc_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       mem_write,
   output logic       iord,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] aluop,
   output logic       ext_op,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic [1:0] pc_source,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC_R   = 4'd6,
      R_WB     = 4'd7,
      EXEC_I   = 4'd8,
      I_WB     = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_SLT  = 3'b100;
   localparam logic [2:0] ALU_LUI  = 3'b101;

   state_t     cur_state;
   logic [2:0] wb_aluop;
   logic       wb_ext_op;
   logic       is_store;
   logic       r_valid;
   logic [2:0] r_aluop;
   logic [2:0] i_aluop;

   always_comb begin
      r_valid = 1'b1;
      r_aluop = ALU_ADD;
      case (funct)
         FN_ADDU: r_aluop = ALU_ADD;
         FN_SUBU: r_aluop = ALU_SUB;
         FN_AND:  r_aluop = ALU_AND;
         FN_OR:   r_aluop = ALU_OR;
         FN_SLT:  r_aluop = ALU_SLT;
         default: r_valid = 1'b0;
      endcase
   end

   always_comb begin
      i_aluop = ALU_ADD;
      case (op)
         OP_ORI:  i_aluop = ALU_OR;
         OP_LUI:  i_aluop = ALU_LUI;
         default: i_aluop = ALU_ADD;
      endcase
   end

   // Writeback states repeat the execute-stage ALU setup, so it is captured
   // here; the load/store choice is also recorded so MEM_ADDR ignores op.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= FETCH;
         wb_aluop  <= ALU_ADD;
         wb_ext_op <= 1'b0;
         is_store  <= 1'b0;
      end else begin
         case (cur_state)
            FETCH: cur_state <= DECODE;
            DECODE: begin
               is_store <= (op == OP_SW);
               case (op)
                  OP_LW, OP_SW:            cur_state <= MEM_ADDR;
                  OP_RTYPE:                cur_state <= r_valid ? EXEC_R : FETCH;
                  OP_ADDIU, OP_ORI, OP_LUI: cur_state <= EXEC_I;
                  OP_BEQ:                  cur_state <= BRANCH;
                  OP_J:                    cur_state <= JUMP;
                  default:                 cur_state <= FETCH;
               endcase
            end
            MEM_ADDR: cur_state <= is_store ? MEM_WR : MEM_RD;
            MEM_RD:   cur_state <= MEM_WB;
            EXEC_R: begin
               wb_aluop  <= r_aluop;
               cur_state <= R_WB;
            end
            EXEC_I: begin
               wb_aluop  <= i_aluop;
               wb_ext_op <= (op == OP_ADDIU);
               cur_state <= I_WB;
            end
            default: cur_state <= FETCH;
         endcase
      end
   end

   assign state = cur_state;

   // Moore decode; reset overrides everything so an abandoned instruction
   // can never write the PC, register file or memory.
   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      aluop      = ALU_ADD;
      ext_op     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      pc_source  = 2'd0;
      case (cur_state)
         FETCH: begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'd1;
         end
         DECODE: begin
            alu_src_b = 2'd3;
            ext_op    = 1'b1;
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            ext_op    = 1'b1;
         end
         MEM_RD: iord = 1'b1;
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEM_WR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         EXEC_R: begin
            alu_src_a = 1'b1;
            aluop     = r_aluop;
         end
         R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            aluop     = wb_aluop;
         end
         EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            aluop     = i_aluop;
            ext_op    = (op == OP_ADDIU);
         end
         I_WB: begin
            reg_write = 1'b1;
            aluop     = wb_aluop;
            ext_op    = wb_ext_op;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            aluop     = ALU_SUB;
            pc_source = 2'd1;
            pc_write  = zero;
         end
         JUMP: begin
            pc_source = 2'd2;
            pc_write  = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         mem_write  = 1'b0;
         iord       = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'd0;
         aluop      = ALU_ADD;
         ext_op     = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         pc_source  = 2'd0;
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus random instruction
// streams compared against a table-driven model of the instruction sequences.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pc_write, ir_write, reg_write, mem_write, iord, alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] aluop;
   logic       ext_op, reg_dst, mem_to_reg;
   logic [1:0] pc_source;
   logic [3:0] state;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       reg_write;
      logic       mem_write;
      logic       iord;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] aluop;
      logic       ext_op;
      logic       reg_dst;
      logic       mem_to_reg;
      logic [1:0] pc_source;
   } ctrl_t;

   ctrl_t obs;
   int    n_checks = 0;
   int    n_fail   = 0;
   int    exp_path[8];
   int    exp_len;

   always #5 clk = ~clk;

   mc_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
      .mem_write(mem_write), .iord(iord), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .aluop(aluop), .ext_op(ext_op),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_source(pc_source),
      .state(state)
   );

   assign obs = '{pc_write, ir_write, reg_write, mem_write, iord, alu_src_a,
                  alu_src_b, aluop, ext_op, reg_dst, mem_to_reg, pc_source};

   function automatic logic [2:0] r_alu(input logic [5:0] f);
      case (f)
         6'h23:   return 3'b001;
         6'h24:   return 3'b010;
         6'h25:   return 3'b011;
         6'h2A:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic bit r_ok(input logic [5:0] f);
      return (f == 6'h21) || (f == 6'h23) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2A);
   endfunction

   // Expected state walk for one instruction, from the per-class latency table.
   function automatic void build_path(input logic [5:0] o, input logic [5:0] f);
      exp_path[0] = 0;
      exp_path[1] = 1;
      case (o)
         6'h00:   if (r_ok(f)) begin exp_path[2] = 6; exp_path[3] = 7; exp_len = 4; end
                  else exp_len = 2;
         6'h23:   begin exp_path[2] = 2; exp_path[3] = 3; exp_path[4] = 4; exp_len = 5; end
         6'h2B:   begin exp_path[2] = 2; exp_path[3] = 5; exp_len = 4; end
         6'h09, 6'h0D, 6'h0F: begin exp_path[2] = 8; exp_path[3] = 9; exp_len = 4; end
         6'h04:   begin exp_path[2] = 10; exp_len = 3; end
         6'h02:   begin exp_path[2] = 11; exp_len = 3; end
         default: exp_len = 2;
      endcase
   endfunction

   function automatic ctrl_t exp_ctrl(input int st, input logic [5:0] o,
                                      input logic [5:0] f, input logic z);
      ctrl_t c;
      logic [2:0] ia;
      c  = '0;
      ia = (o == 6'h0D) ? 3'b011 : (o == 6'h0F) ? 3'b101 : 3'b000;
      case (st)
         0:  begin c.pc_write = 1; c.ir_write = 1; c.alu_src_b = 2'd1; end
         1:  begin c.alu_src_b = 2'd3; c.ext_op = 1; end
         2:  begin c.alu_src_a = 1; c.alu_src_b = 2'd2; c.ext_op = 1; end
         3:  c.iord = 1;
         4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
         5:  begin c.iord = 1; c.mem_write = 1; end
         6:  begin c.alu_src_a = 1; c.aluop = r_alu(f); end
         7:  begin c.reg_write = 1; c.reg_dst = 1; c.aluop = r_alu(f); end
         8:  begin c.alu_src_a = 1; c.alu_src_b = 2'd2; c.aluop = ia; c.ext_op = (o == 6'h09); end
         9:  begin c.reg_write = 1; c.aluop = ia; c.ext_op = (o == 6'h09); end
         10: begin c.alu_src_a = 1; c.aluop = 3'b001; c.pc_source = 2'd1; c.pc_write = z; end
         11: begin c.pc_source = 2'd2; c.pc_write = 1; end
         default: ;
      endcase
      return c;
   endfunction

   // zmode: 0/1 drive zero constant, 2 randomize it every cycle.
   task automatic run_instr(input string name, input logic [5:0] o,
                            input logic [5:0] f, input int zmode);
      ctrl_t want;
      build_path(o, f);
      for (int i = 0; i < exp_len; i++) begin
         @(negedge clk);
         op    = o;
         funct = f;
         zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         #1;
         want = exp_ctrl(exp_path[i], o, f, zero);
         n_checks++;
         if (state !== 4'(exp_path[i])) begin
            n_fail++;
            $display("[TB] FAIL %s state cyc%0d op=%h fn=%h: got %0d want %0d",
                     name, i, o, f, state, exp_path[i]);
         end
         n_checks++;
         if (obs !== want) begin
            n_fail++;
            $display("[TB] FAIL %s ctrl cyc%0d st=%0d op=%h fn=%h: got %h want %h",
                     name, i, exp_path[i], o, f, obs, want);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; op = 6'h00; funct = 6'h21; zero = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (state !== 4'd0 || obs !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_hold: got state %0d ctrl %h want 0/0", state, obs);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (state !== 4'd0 || obs !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_hold2: got state %0d ctrl %h want 0/0", state, obs);
      end
      reset = 1'b0;
      run_instr("addu", 6'h00, 6'h21, 0);
   endtask

   task automatic test_mem();
      run_instr("lw", 6'h23, 6'h00, 0);
      run_instr("sw", 6'h2B, 6'h15, 1);
   endtask

   task automatic test_beq();
      run_instr("beq_z1", 6'h04, 6'h00, 1);
      run_instr("beq_z0", 6'h04, 6'h00, 0);
   endtask

   task automatic test_itype();
      run_instr("ori", 6'h0D, 6'h3F, 0);
      run_instr("lui", 6'h0F, 6'h00, 0);
      run_instr("addiu", 6'h09, 6'h2A, 1);
      run_instr("subu", 6'h00, 6'h23, 0);
      run_instr("slt", 6'h00, 6'h2A, 0);
   endtask

   task automatic test_nop_and_reset_mid();
      run_instr("bad_funct", 6'h00, 6'h00, 0);
      run_instr("bad_op", 6'h3F, 6'h21, 0);
      run_instr("j", 6'h02, 6'h00, 0);
      reset = 1'b1;
      #1;
      n_checks++;
      if (state !== 4'd11 || obs !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_in_jump: got state %0d ctrl %h want 11/0", state, obs);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (state !== 4'd0 || obs !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_after_jump: got state %0d ctrl %h want 0/0", state, obs);
      end
      reset = 1'b0;
   endtask

   task automatic test_random();
      logic [5:0] ops[8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h09, 6'h0D, 6'h0F};
      logic [5:0] fns[5] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};
      logic [5:0] o, f;
      for (int n = 0; n < 60; n++) begin
         o = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
         f = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
         run_instr("random", o, f, 2);
      end
   endtask

   initial begin
      test_reset();
      test_mem();
      test_beq();
      test_itype();
      test_nop_and_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main control FSM for the CPU datapath; sits directly upstream of the ALU.
- Decodes op/funct from the instruction register and sequences fetch, decode, execute, memory and writeback over several clocks.
- Drives aluop and the ALU operand selects each cycle, plus PC, IR, register-file and memory enables.
- The ALU zero flag returns to it for beq resolution.

Parameters:
- none; state and aluop encodings are fixed below.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU result==0, combinational from ALU in same cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  IR load enable
- reg_write  out  1  register-file write enable
- mem_write  out  1  data memory write enable
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- alu_src_a  out  1  ALU A select: 0=PC, 1=rs data
- alu_src_b  out  2  ALU B select: 0=rt data, 1=const 4, 2=ext(imm), 3=sign-ext(imm)<<2
- aluop  out  3  ALU operation: ADD=000, SUB=001, AND=010, OR=011, SLT=100, LUI=101
- ext_op  out  1  immediate extension: 0=zero, 1=sign
- reg_dst  out  1  write register: 0=rt, 1=rd
- mem_to_reg  out  1  writeback data: 0=ALUOut, 1=MDR
- pc_source  out  2  next PC: 0=ALU result, 1=ALUOut, 2={PC[31:28],IR[25:0],2'b00}
- state  out  4  current state, debug

Behaviour:
- Moore FSM. Outputs decode combinationally from state; any output not listed for a state is 0, so aluop defaults to ADD.
- While reset is high, every output except state is forced to 0.
- On reset, the state register loads FETCH (0) at the clock edge. Reset mid-instruction abandons it with no partial write.
- Supported instructions:
  - R-type (op 000000): addu 100001, subu 100011, and 100100, or 100101, slt 101010
  - addiu 001001, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010
- FETCH(0): ir_write=1, pc_write=1, alu_src_b=1, aluop=ADD -> DECODE.
- DECODE(1): alu_src_b=3, ext_op=1, aluop=ADD (branch target into ALUOut). Next state by instruction:
  - lw/sw -> MEM_ADDR
  - valid R-type -> EXEC_R
  - addiu/ori/lui -> EXEC_I
  - beq -> BRANCH
  - j -> JUMP
  - unknown op, or R-type with unknown funct -> FETCH (NOP, 2 cycles, no writes)
- MEM_ADDR(2): alu_src_a=1, alu_src_b=2, ext_op=1, aluop=ADD. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD(3): iord=1 -> MEM_WB.
- MEM_WB(4): reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WR(5): iord=1, mem_write=1 -> FETCH.
- EXEC_R(6): alu_src_a=1, alu_src_b=0. aluop by funct: addu ADD, subu SUB, and AND, or OR, slt SLT. -> R_WB.
- R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0; aluop held as in EXEC_R -> FETCH.
- EXEC_I(8): alu_src_a=1, alu_src_b=2 -> I_WB. Per instruction:
  - addiu: ADD, ext_op=1
  - ori: OR, ext_op=0
  - lui: LUI, ext_op=0
- I_WB(9): reg_write=1, reg_dst=0; EXEC_I aluop/ext_op held -> FETCH.
- BRANCH(10): alu_src_a=1, alu_src_b=0, aluop=SUB, pc_source=1, pc_write=zero -> FETCH.
- JUMP(11): pc_source=2, pc_write=1 -> FETCH.
- Codes 12-15 are unreachable; if entered, all outputs are 0 and the next state is FETCH.
- Latency in cycles: R/I-type 4, lw 5, sw 4, beq 3, j 3, NOP 2.
- op/funct are sampled only in DECODE, EXEC_R and EXEC_I. IR is stable because ir_write is asserted only in FETCH.

Test Plan:
- reset=1 for 2 clks, then release with op=0, funct=0x21 -> during reset all controls 0, state=0. Sequence 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; aluop=000 in state 6.
- lw (op 0x23) -> states 0,1,2,3,4,0. iord=1 in 3. reg_write=1, mem_to_reg=1 in 4. mem_write never 1.
- sw (op 0x2B) -> states 0,1,2,5,0. mem_write=1 only in 5; reg_write never 1.
- beq (op 0x04), zero=1 then a repeat with zero=0 -> state 10, aluop=001, pc_source=1 in both runs; pc_write=1 in the first run, 0 in the second.
- ori (op 0x0D), then lui (op 0x0F) -> state 8: ori gives aluop=011, ext_op=0; lui gives aluop=101. Both pass through state 9 with reg_write=1, reg_dst=0.
- R-type funct=0x00, then op=0x3F, then j (op 0x02) mid-run with reset asserted in state 11 -> first two: states 0,1,0 with no writes. j: reset in 11 forces outputs 0, and state=0 next clock.
